// File: rtl/rip_csr_unit.sv
// Machine-mode CSR unit for the RIP core.
// Handles CSRRW/CSRRS/CSRRC accesses, the mcycle/minstret counters, trap entry and MRET.
// The CSR read path and the PC redirect are combinational.
// All other state is held in flops with an asynchronous active-low reset.
// The counters are split at bit 32. The high halves exist only when COUNTER_W > 32.
module rip_csr_unit #(
    parameter int              XLEN        = 32,
    parameter int              COUNTER_W   = 64,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            csr_valid,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,

    input  logic            retire,

    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_valid,

    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            mie
);

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;

    localparam bit HAS_HI = (COUNTER_W > 32);

    // architectural state
    logic                 mie_q;
    logic                 mpie_q;
    logic [XLEN-1:0]      mtvec_q;
    logic [XLEN-1:0]      mscratch_q;
    logic [XLEN-1:0]      mepc_q;
    logic [XLEN-1:0]      mcause_q;
    logic [COUNTER_W-1:0] mcycle_q;
    logic [COUNTER_W-1:0] minstret_q;

    // decode / datapath
    logic [XLEN-1:0]      mstatus_rd;
    logic [XLEN-1:0]      rd_val;
    logic                 addr_hit;
    logic                 addr_hi_half;
    logic                 addr_ro;
    logic                 access;
    logic                 wants_write;
    logic                 do_write;
    logic [XLEN-1:0]      wval;
    logic [63:0]          cyc_x;
    logic [63:0]          ins_x;
    logic [63:0]          cyc_w;
    logic [63:0]          ins_w;
    logic [COUNTER_W-1:0] mcycle_d;
    logic [COUNTER_W-1:0] minstret_d;
    logic [XLEN-1:0]      mtvec_base;
    logic [XLEN-1:0]      vec_offset;

    logic we_mstatus;
    logic we_mtvec;
    logic we_mscratch;
    logic we_mepc;
    logic we_mcause;
    logic we_cyc_lo;
    logic we_cyc_hi;
    logic we_ins_lo;
    logic we_ins_hi;

    assign cyc_x = 64'(mcycle_q);
    assign ins_x = 64'(minstret_q);

    // mstatus view: MPP is hardwired to machine mode, only MIE/MPIE are live
    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mpie_q;
        mstatus_rd[3]     = mie_q;
    end

    // address decode and read mux
    always_comb begin
        rd_val       = '0;
        addr_hit     = 1'b1;
        addr_hi_half = 1'b0;
        unique case (csr_addr)
            A_MSTATUS:  rd_val = mstatus_rd;
            A_MTVEC:    rd_val = mtvec_q;
            A_MSCRATCH: rd_val = mscratch_q;
            A_MEPC:     rd_val = mepc_q;
            A_MCAUSE:   rd_val = mcause_q;
            A_MCYCLE, A_CYCLE:         rd_val = XLEN'(cyc_x[31:0]);
            A_MINSTRET, A_INSTRET:     rd_val = XLEN'(ins_x[31:0]);
            A_MCYCLEH, A_CYCLEH: begin
                rd_val       = XLEN'(cyc_x[63:32]);
                addr_hi_half = 1'b1;
            end
            A_MINSTRETH, A_INSTRETH: begin
                rd_val       = XLEN'(ins_x[63:32]);
                addr_hi_half = 1'b1;
            end
            default:    addr_hit = 1'b0;
        endcase
    end

    // Legality check. RS/RC with zero wdata are pure reads, so they are allowed on the 0xCxx shadows.
    always_comb begin
        addr_ro     = (csr_addr[11:10] == 2'b11);
        access      = csr_valid & (csr_op != 2'b00);
        wants_write = (csr_op == OP_RW) | (csr_wdata != '0);
        csr_illegal = access & (~addr_hit
                              | (addr_ro & wants_write)
                              | (addr_hi_half & ~HAS_HI));
        do_write    = access & ~csr_illegal & wants_write;
        csr_rdata   = csr_illegal ? '0 : rd_val;
    end

    // write value from the read-modify-write op
    always_comb begin
        wval = rd_val;
        unique case (csr_op)
            OP_RW:   wval = csr_wdata;
            OP_RS:   wval = rd_val | csr_wdata;
            OP_RC:   wval = rd_val & ~csr_wdata;
            default: wval = rd_val;
        endcase
    end

    // Per-register write enables.
    // A trap owns mepc, mcause and mstatus. MRET owns mstatus.
    // CSR writes to the other registers are not affected.
    always_comb begin
        we_mstatus  = do_write & (csr_addr == A_MSTATUS) & ~trap_valid & ~mret_valid;
        we_mtvec    = do_write & (csr_addr == A_MTVEC);
        we_mscratch = do_write & (csr_addr == A_MSCRATCH);
        we_mepc     = do_write & (csr_addr == A_MEPC) & ~trap_valid;
        we_mcause   = do_write & (csr_addr == A_MCAUSE) & ~trap_valid;
        we_cyc_lo   = do_write & (csr_addr == A_MCYCLE);
        we_cyc_hi   = do_write & (csr_addr == A_MCYCLEH);
        we_ins_lo   = do_write & (csr_addr == A_MINSTRET);
        we_ins_hi   = do_write & (csr_addr == A_MINSTRETH);
    end

    // Counter next values.
    // A write to either half replaces that half and suppresses the increment for that cycle.
    always_comb begin
        cyc_w = cyc_x;
        if (we_cyc_lo) cyc_w[31:0]  = wval[31:0];
        if (we_cyc_hi) cyc_w[63:32] = wval[31:0];
        if (we_cyc_lo | we_cyc_hi) mcycle_d = COUNTER_W'(cyc_w);
        else                       mcycle_d = mcycle_q + COUNTER_W'(1);

        ins_w = ins_x;
        if (we_ins_lo) ins_w[31:0]  = wval[31:0];
        if (we_ins_hi) ins_w[63:32] = wval[31:0];
        if (we_ins_lo | we_ins_hi) minstret_d = COUNTER_W'(ins_w);
        else if (retire)           minstret_d = minstret_q + COUNTER_W'(1);
        else                       minstret_d = minstret_q;
    end

    // Redirect target.
    // Vectored mode offsets only interrupts. {cause, 2'b00} is 4*cause[XLEN-2:0] truncated to XLEN.
    always_comb begin
        mtvec_base     = {mtvec_q[XLEN-1:2], 2'b00};
        vec_offset     = (mtvec_q[0] & trap_cause[XLEN-1])
                         ? {trap_cause[XLEN-3:0], 2'b00} : '0;
        redirect_valid = trap_valid | mret_valid;
        redirect_pc    = trap_valid ? (mtvec_base + vec_offset) : mepc_q;
    end

    // mstatus: trap beats MRET beats CSR write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q  <= 1'b0;
            mpie_q <= 1'b0;
        end else if (trap_valid) begin
            mpie_q <= mie_q;
            mie_q  <= 1'b0;
        end else if (mret_valid) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end else if (we_mstatus) begin
            mie_q  <= wval[3];
            mpie_q <= wval[7];
        end
    end

    // trap vector and scratch; the reserved mode encodings 1x collapse to direct
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtvec_q    <= RESET_MTVEC;
            mscratch_q <= '0;
        end else begin
            if (we_mtvec)
                mtvec_q <= {wval[XLEN-1:2], (wval[1] ? 2'b00 : wval[1:0])};
            if (we_mscratch)
                mscratch_q <= wval;
        end
    end

    // exception PC and cause; mepc is kept word-aligned in storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mepc_q   <= '0;
            mcause_q <= '0;
        end else if (trap_valid) begin
            mepc_q   <= {trap_pc[XLEN-1:2], 2'b00};
            mcause_q <= trap_cause;
        end else begin
            if (we_mepc)   mepc_q   <= {wval[XLEN-1:2], 2'b00};
            if (we_mcause) mcause_q <= wval;
        end
    end

    // free-running cycle and retired-instruction counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign mie = mie_q;

endmodule

// File: tb/tb_rip_csr_unit.sv
// Self-checking bench for rip_csr_unit: scoreboard of per-cycle expectations.
module tb_rip_csr_unit;

    localparam logic [31:0] RST_TVEC = 32'h0000_0400;
    localparam logic [1:0]  OP_RW = 2'b01;
    localparam logic [1:0]  OP_RS = 2'b10;
    localparam logic [1:0]  OP_RC = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        csr_valid;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        retire;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic        mret_valid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mie;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        valid;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wd;
        logic        retire;
        logic        trap;
        logic [31:0] cause;
        logic [31:0] pc;
        logic        mret;
        logic        chk_rd;
        logic [31:0] erd;
        logic        eill;
        logic        erv;
        logic [31:0] erpc;
        logic        emie;
    } step_t;

    step_t exp_q[$];

    rip_csr_unit #(
        .XLEN(32),
        .COUNTER_W(64),
        .RESET_MTVEC(RST_TVEC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .csr_valid(csr_valid),
        .csr_op(csr_op),
        .csr_addr(csr_addr),
        .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata),
        .csr_illegal(csr_illegal),
        .retire(retire),
        .trap_valid(trap_valid),
        .trap_cause(trap_cause),
        .trap_pc(trap_pc),
        .mret_valid(mret_valid),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .mie(mie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    function automatic step_t acc(logic [1:0] op, logic [11:0] addr, logic [31:0] wd,
                                  logic [31:0] erd, logic eill, logic emie);
        step_t s;
        s.valid = 1'b1; s.op = op; s.addr = addr; s.wd = wd;
        s.retire = 1'b0; s.trap = 1'b0; s.cause = '0; s.pc = '0; s.mret = 1'b0;
        s.chk_rd = 1'b1; s.erd = erd; s.eill = eill; s.erv = 1'b0; s.erpc = '0;
        s.emie = emie;
        return s;
    endfunction

    function automatic step_t rd(logic [11:0] addr, logic [31:0] erd, logic emie);
        return acc(OP_RS, addr, 32'h0, erd, 1'b0, emie);
    endfunction

    function automatic step_t idle_step(logic emie);
        step_t s;
        s = acc(2'b00, 12'h000, 32'h0, 32'h0, 1'b0, emie);
        s.valid = 1'b0;
        return s;
    endfunction

    function automatic step_t trap_step(logic [31:0] cause, logic [31:0] pc,
                                        logic [31:0] erpc, logic emie);
        step_t s;
        s = idle_step(emie);
        s.trap = 1'b1; s.cause = cause; s.pc = pc; s.erv = 1'b1; s.erpc = erpc;
        return s;
    endfunction

    function automatic step_t mret_step(logic [31:0] erpc, logic emie);
        step_t s;
        s = idle_step(emie);
        s.mret = 1'b1; s.erv = 1'b1; s.erpc = erpc;
        return s;
    endfunction

    // drive one cycle of stimulus and record what the DUT must show for it
    task automatic apply_step(input step_t s);
        csr_valid  = s.valid;
        csr_op     = s.op;
        csr_addr   = s.addr;
        csr_wdata  = s.wd;
        retire     = s.retire;
        trap_valid = s.trap;
        trap_cause = s.cause;
        trap_pc    = s.pc;
        mret_valid = s.mret;
        exp_q.push_back(s);
    endtask

    task automatic test_reset();
        step_t s[$];
        step_t e;
        rst_n = 1'b0;
        apply_step(idle_step(1'b0));
        void'(exp_q.pop_front());
        repeat (3) @(posedge clk);
        #1;
        apply_step(rd(12'h300, 32'h0000_1800, 1'b0));
        #1;
        e = exp_q.pop_front();
        checks++;
        if (csr_rdata !== e.erd) begin
            errors++;
            $display("FAIL reset_hold_mstatus: got %h required %h", csr_rdata, e.erd);
        end
        checks++;
        if (mie !== e.emie || redirect_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold_outputs: got mie=%b rv=%b required 0 0", mie, redirect_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        s.push_back(rd(12'hB00, 32'd5, 1'b0));
        s.push_back(rd(12'hC00, 32'd6, 1'b0));
        s.push_back(rd(12'hB80, 32'd0, 1'b0));
        s.push_back(rd(12'h300, 32'h0000_1800, 1'b0));
        s.push_back(rd(12'h305, RST_TVEC, 1'b0));
        s.push_back(rd(12'h340, 32'h0, 1'b0));
        s.push_back(rd(12'h341, 32'h0, 1'b0));
        s.push_back(rd(12'h342, 32'h0, 1'b0));
        s.push_back(rd(12'hB02, 32'h0, 1'b0));
        s.push_back(rd(12'hC82, 32'h0, 1'b0));
        foreach (s[i]) begin
            apply_step(s[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (csr_rdata !== e.erd) begin
                errors++;
                $display("FAIL reset[%0d] rdata addr %h: got %h required %h", i, e.addr, csr_rdata, e.erd);
            end
            checks++;
            if (csr_illegal !== e.eill || redirect_valid !== e.erv || mie !== e.emie) begin
                errors++;
                $display("FAIL reset[%0d] flags: got ill=%b rv=%b mie=%b required %b %b %b",
                         i, csr_illegal, redirect_valid, mie, e.eill, e.erv, e.emie);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_csr_ops();
        step_t s[$];
        step_t e;
        s.push_back(acc(OP_RW, 12'h305, 32'h8000_0001, RST_TVEC, 1'b0, 1'b0));
        s.push_back(acc(OP_RS, 12'h300, 32'h8, 32'h0000_1800, 1'b0, 1'b0));
        s.push_back(rd(12'h305, 32'h8000_0001, 1'b1));
        s.push_back(acc(OP_RC, 12'h300, 32'h8, 32'h0000_1808, 1'b0, 1'b1));
        s.push_back(rd(12'h300, 32'h0000_1800, 1'b0));
        s.push_back(acc(OP_RW, 12'h305, 32'h0000_1236, 32'h8000_0001, 1'b0, 1'b0));
        s.push_back(acc(OP_RW, 12'h305, 32'h8000_0001, 32'h0000_1234, 1'b0, 1'b0));
        s.push_back(acc(OP_RW, 12'h340, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0));
        s.push_back(acc(OP_RC, 12'h340, 32'h0000_00FF, 32'hDEAD_BEEF, 1'b0, 1'b0));
        s.push_back(acc(OP_RS, 12'h340, 32'h1, 32'hDEAD_BE00, 1'b0, 1'b0));
        s.push_back(rd(12'h340, 32'hDEAD_BE01, 1'b0));
        s.push_back(acc(OP_RW, 12'h300, 32'hFFFF_FFFF, 32'h0000_1800, 1'b0, 1'b0));
        s.push_back(acc(OP_RW, 12'h300, 32'h0, 32'h0000_1888, 1'b0, 1'b1));
        s.push_back(rd(12'h300, 32'h0000_1800, 1'b0));
        s.push_back(acc(OP_RW, 12'h341, 32'h0000_0207, 32'h0, 1'b0, 1'b0));
        s.push_back(rd(12'h341, 32'h0000_0204, 1'b0));
        foreach (s[i]) begin
            apply_step(s[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (csr_rdata !== e.erd) begin
                errors++;
                $display("FAIL csr_ops[%0d] rdata addr %h: got %h required %h", i, e.addr, csr_rdata, e.erd);
            end
            checks++;
            if (csr_illegal !== e.eill || mie !== e.emie) begin
                errors++;
                $display("FAIL csr_ops[%0d] flags: got ill=%b mie=%b required %b %b",
                         i, csr_illegal, mie, e.eill, e.emie);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_trap_mret();
        step_t s[$];
        step_t e;
        s.push_back(acc(OP_RS, 12'h300, 32'h8, 32'h0000_1800, 1'b0, 1'b0));
        s.push_back(trap_step(32'h8000_0007, 32'h0000_0100, 32'h8000_001C, 1'b1));
        s.push_back(rd(12'h341, 32'h0000_0100, 1'b0));
        s.push_back(rd(12'h342, 32'h8000_0007, 1'b0));
        s.push_back(rd(12'h300, 32'h0000_1880, 1'b0));
        s.push_back(mret_step(32'h0000_0100, 1'b0));
        s.push_back(rd(12'h300, 32'h0000_1888, 1'b1));
        s.push_back(trap_step(32'h0000_0002, 32'h0000_0500, 32'h8000_0000, 1'b1));
        s.push_back(rd(12'h300, 32'h0000_1880, 1'b0));
        s.push_back(acc(OP_RW, 12'h305, 32'h0000_2000, 32'h8000_0001, 1'b0, 1'b0));
        s.push_back(trap_step(32'h8000_0003, 32'h0000_0500, 32'h0000_2000, 1'b0));
        s.push_back(rd(12'h300, 32'h0000_1800, 1'b0));
        s.push_back(rd(12'h341, 32'h0000_0500, 1'b0));
        foreach (s[i]) begin
            apply_step(s[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (csr_rdata !== e.erd) begin
                errors++;
                $display("FAIL trap[%0d] rdata: got %h required %h", i, csr_rdata, e.erd);
            end
            checks++;
            if (redirect_valid !== e.erv || mie !== e.emie) begin
                errors++;
                $display("FAIL trap[%0d] rv/mie: got %b %b required %b %b",
                         i, redirect_valid, mie, e.erv, e.emie);
            end
            if (e.erv) begin
                checks++;
                if (redirect_pc !== e.erpc) begin
                    errors++;
                    $display("FAIL trap[%0d] redirect_pc: got %h required %h", i, redirect_pc, e.erpc);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_counters();
        step_t s[$];
        step_t st;
        step_t e;
        st = acc(OP_RW, 12'hB00, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        st.chk_rd = 1'b0;
        s.push_back(st);
        s.push_back(acc(OP_RW, 12'hB80, 32'h0, 32'h0, 1'b0, 1'b0));
        s.push_back(idle_step(1'b0));
        s.push_back(rd(12'hB00, 32'h0, 1'b0));
        s.push_back(rd(12'hB80, 32'h1, 1'b0));
        s.push_back(rd(12'hB00, 32'h2, 1'b0));
        s.push_back(acc(OP_RW, 12'hB80, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0));
        s.push_back(acc(OP_RW, 12'hB00, 32'hFFFF_FFFF, 32'h3, 1'b0, 1'b0));
        s.push_back(rd(12'hB80, 32'hFFFF_FFFF, 1'b0));
        s.push_back(rd(12'hB80, 32'h0, 1'b0));
        s.push_back(rd(12'hB00, 32'h1, 1'b0));
        st = acc(OP_RW, 12'hB02, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        st.retire = 1'b1;
        s.push_back(st);
        st = acc(OP_RW, 12'hB82, 32'h0, 32'h0, 1'b0, 1'b0);
        st.retire = 1'b1;
        s.push_back(st);
        st = idle_step(1'b0);
        st.retire = 1'b1;
        s.push_back(st);
        s.push_back(rd(12'hB02, 32'h0, 1'b0));
        s.push_back(rd(12'hB82, 32'h1, 1'b0));
        s.push_back(rd(12'hC82, 32'h1, 1'b0));
        st = rd(12'hC02, 32'h0, 1'b0);
        st.retire = 1'b1;
        s.push_back(st);
        s.push_back(rd(12'hC02, 32'h1, 1'b0));
        foreach (s[i]) begin
            apply_step(s[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            if (e.chk_rd) begin
                checks++;
                if (csr_rdata !== e.erd) begin
                    errors++;
                    $display("FAIL counters[%0d] rdata addr %h: got %h required %h",
                             i, e.addr, csr_rdata, e.erd);
                end
            end
            checks++;
            if (csr_illegal !== e.eill) begin
                errors++;
                $display("FAIL counters[%0d] illegal: got %b required %b", i, csr_illegal, e.eill);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_illegal();
        step_t s[$];
        step_t st;
        step_t e;
        st = acc(OP_RW, 12'hB00, 32'h0000_1000, 32'h0, 1'b0, 1'b0);
        st.chk_rd = 1'b0;
        s.push_back(st);
        s.push_back(acc(OP_RW, 12'hC00, 32'h5, 32'h0, 1'b1, 1'b0));
        s.push_back(rd(12'hC00, 32'h0000_1001, 1'b0));
        s.push_back(acc(OP_RS, 12'hC00, 32'h4, 32'h0, 1'b1, 1'b0));
        s.push_back(acc(OP_RW, 12'h7C0, 32'h5, 32'h0, 1'b1, 1'b0));
        s.push_back(acc(OP_RS, 12'h7C0, 32'h0, 32'h0, 1'b1, 1'b0));
        s.push_back(acc(OP_RC, 12'hC80, 32'h0, 32'h0, 1'b0, 1'b0));
        s.push_back(acc(2'b00, 12'h7C0, 32'h5, 32'h0, 1'b0, 1'b0));
        s.push_back(acc(OP_RC, 12'h301, 32'h1, 32'h0, 1'b1, 1'b0));
        s.push_back(rd(12'hC00, 32'h0000_1008, 1'b0));
        s.push_back(acc(OP_RC, 12'hC82, 32'h1, 32'h0, 1'b1, 1'b0));
        foreach (s[i]) begin
            apply_step(s[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            if (e.chk_rd) begin
                checks++;
                if (csr_rdata !== e.erd) begin
                    errors++;
                    $display("FAIL illegal[%0d] rdata addr %h: got %h required %h",
                             i, e.addr, csr_rdata, e.erd);
                end
            end
            checks++;
            if (csr_illegal !== e.eill) begin
                errors++;
                $display("FAIL illegal[%0d] csr_illegal addr %h: got %b required %b",
                         i, e.addr, csr_illegal, e.eill);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_priority();
        step_t s[$];
        step_t st;
        step_t e;
        s.push_back(acc(OP_RW, 12'h305, 32'h8000_0001, 32'h0000_2000, 1'b0, 1'b0));
        st = acc(OP_RW, 12'hB02, 32'h0000_0010, 32'h0, 1'b0, 1'b0);
        st.chk_rd = 1'b0;
        s.push_back(st);
        s.push_back(acc(OP_RW, 12'h300, 32'h8, 32'h0000_1800, 1'b0, 1'b0));
        st = acc(OP_RW, 12'h341, 32'h0000_0200, 32'h0000_0500, 1'b0, 1'b1);
        st.trap = 1'b1; st.cause = 32'h5; st.pc = 32'h0000_0440;
        st.mret = 1'b1; st.retire = 1'b1; st.erv = 1'b1; st.erpc = 32'h8000_0000;
        s.push_back(st);
        s.push_back(rd(12'h341, 32'h0000_0440, 1'b0));
        s.push_back(rd(12'h300, 32'h0000_1880, 1'b0));
        s.push_back(rd(12'hB02, 32'h0000_0011, 1'b0));
        st = acc(OP_RW, 12'h300, 32'h0, 32'h0000_1880, 1'b0, 1'b0);
        st.mret = 1'b1; st.erv = 1'b1; st.erpc = 32'h0000_0440;
        s.push_back(st);
        s.push_back(rd(12'h300, 32'h0000_1888, 1'b1));
        st = acc(OP_RW, 12'h340, 32'h0000_0055, 32'hDEAD_BE01, 1'b0, 1'b1);
        st.trap = 1'b1; st.cause = 32'h0; st.pc = 32'h0000_0600;
        st.erv = 1'b1; st.erpc = 32'h8000_0000;
        s.push_back(st);
        s.push_back(rd(12'h340, 32'h0000_0055, 1'b0));
        s.push_back(rd(12'h342, 32'h0, 1'b0));
        foreach (s[i]) begin
            apply_step(s[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            if (e.chk_rd) begin
                checks++;
                if (csr_rdata !== e.erd) begin
                    errors++;
                    $display("FAIL priority[%0d] rdata: got %h required %h", i, csr_rdata, e.erd);
                end
            end
            checks++;
            if (redirect_valid !== e.erv || mie !== e.emie) begin
                errors++;
                $display("FAIL priority[%0d] rv/mie: got %b %b required %b %b",
                         i, redirect_valid, mie, e.erv, e.emie);
            end
            if (e.erv) begin
                checks++;
                if (redirect_pc !== e.erpc) begin
                    errors++;
                    $display("FAIL priority[%0d] redirect_pc: got %h required %h", i, redirect_pc, e.erpc);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        step_t s[$];
        step_t e;
        apply_step(acc(OP_RS, 12'h300, 32'h8, 32'h0000_1880, 1'b0, 1'b0));
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (csr_rdata !== e.erd) begin
            errors++;
            $display("FAIL reset_mid_pre rdata: got %h required %h", csr_rdata, e.erd);
        end
        @(posedge clk);
        #1;
        checks++;
        if (mie !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_set mie: got %b required 1", mie);
        end
        #2;
        rst_n = 1'b0;
        apply_step(rd(12'h305, RST_TVEC, 1'b0));
        #1;
        e = exp_q.pop_front();
        checks++;
        if (mie !== e.emie) begin
            errors++;
            $display("FAIL reset_mid_async mie: got %b required %b", mie, e.emie);
        end
        checks++;
        if (csr_rdata !== e.erd) begin
            errors++;
            $display("FAIL reset_mid_async mtvec: got %h required %h", csr_rdata, e.erd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply_step(idle_step(1'b0));
        void'(exp_q.pop_front());
        @(posedge clk);
        #1;
        s.push_back(rd(12'hB00, 32'h1, 1'b0));
        s.push_back(rd(12'hB02, 32'h0, 1'b0));
        s.push_back(rd(12'h300, 32'h0000_1800, 1'b0));
        s.push_back(rd(12'h341, 32'h0, 1'b0));
        foreach (s[i]) begin
            apply_step(s[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (csr_rdata !== e.erd || mie !== e.emie) begin
                errors++;
                $display("FAIL reset_mid[%0d] addr %h: got rdata=%h mie=%b required %h %b",
                         i, e.addr, csr_rdata, mie, e.erd, e.emie);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        csr_valid  = 1'b0;
        csr_op     = 2'b00;
        csr_addr   = '0;
        csr_wdata  = '0;
        retire     = 1'b0;
        trap_valid = 1'b0;
        trap_cause = '0;
        trap_pc    = '0;
        mret_valid = 1'b0;
        test_reset();
        test_csr_ops();
        test_trap_mret();
        test_counters();
        test_illegal();
        test_priority();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rip_csr_unit.md
# rip_csr_unit

Machine-mode CSR register file for the RIP core, replacing the fixed 32-bit mstatus/mtvec/mepc/mcause/cycle record with a parametrised, stateful unit. It executes CSRRW/CSRRS/CSRRC accesses, maintains wide cycle and instret counters, and performs trap-entry and MRET state updates. It sits beside the execute stage and drives the PC-redirect path on traps and MRET.

## Interface
- XLEN, 32: data width of CSRs and ports.
- COUNTER_W, 64: width of mcycle/minstret (legal 33..64 split into low/high halves; 32 means no high halves).
- RESET_MTVEC, 32'h0000_0000: reset value of mtvec.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- csr_valid  in  1  CSR access this cycle.
- csr_op  in  2  01 RW, 10 RS (set), 11 RC (clear); 00 treated as no access.
- csr_addr  in  12  CSR address.
- csr_wdata  in  XLEN  rs1 value or zero-extended immediate, resolved upstream.
- csr_rdata  out  XLEN  old value of addressed CSR, combinational.
- csr_illegal  out  1  access is illegal, combinational.
- retire  in  1  one instruction retires this cycle.
- trap_valid  in  1  take trap this cycle.
- trap_cause  in  XLEN  mcause value; bit XLEN-1 set = interrupt.
- trap_pc  in  XLEN  PC written to mepc.
- mret_valid  in  1  MRET executes this cycle.
- redirect_valid  out  1  PC redirect, combinational.
- redirect_pc  out  XLEN  redirect target, combinational.
- mie  out  1  current mstatus.MIE, registered.

## Operation
- Implemented CSRs: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82, read-only shadows cycle 0xC00, instret 0xC02, cycleh 0xC80, instreth 0xC82.
- mstatus: only MIE (bit 3) and MPIE (bit 7) writable; MPP (bits 12:11) reads 2'b11; other bits read 0.
- mepc bits [1:0] read as 0. mtvec[1:0]: 00 direct, 01 vectored; 1x written is stored as 00.
- Write value: RW = wdata; RS = old | wdata; RC = old & ~wdata.
- RS/RC with wdata == 0 perform no write and are legal on read-only CSRs.
- csr_illegal = csr_valid & op != 00 & (unimplemented address, or write to 0xCxx, or high-half address when COUNTER_W == 32). Illegal accesses change no state; csr_rdata = 0.
- Counters: mcycle += 1 every cycle; minstret += 1 when retire. Both wrap from 2^COUNTER_W-1 to 0. High half reads zero-extended bits above 32.
- CSR write to a counter half replaces that half; the counter does not increment that cycle; the other half holds.
- Trap: mepc <= trap_pc, mcause <= trap_cause, MPIE <= MIE, MIE <= 0. redirect_pc = mtvec base (mtvec & ~3); if vectored and cause is interrupt, base + 4*cause[XLEN-2:0].
- MRET: MIE <= MPIE, MPIE <= 1, redirect_pc = mepc.
- Priority in one cycle: trap > mret > CSR write. Lower-priority writes to overlapping state are dropped; counter increments always proceed unless overwritten by an accepted CSR write.
- Trap and MRET in the same cycle: trap only.

## Timing
- Reset (async assert, sync-released by caller): mstatus.MIE=0, MPIE=0, mtvec=RESET_MTVEC, mscratch/mepc/mcause=0, counters=0; mie=0. csr_rdata/redirect outputs follow state (redirect_valid=0 when inputs low).
- Read latency 0: csr_rdata returns the pre-edge value in the same cycle as the access; write visible next cycle.
- redirect_valid = trap_valid | mret_valid, same cycle, using pre-edge mtvec/mepc.
- Reset mid-operation clears all state immediately; counter restarts at 0 on first edge after release (value 1 after that edge).

## Test plan
- Reset, then read 0x300 -> 0x0000_1800; mtvec = RESET_MTVEC; after 5 cycles mcycle reads 5.
- CSRRW mtvec 0x8000_0001 then CSRRS mstatus 0x8 -> mtvec 0x8000_0001, mie=1 next cycle; CSRRC 0x8 -> mie=0.
- trap cause 0x8000_0007, pc 0x100, vectored mtvec 0x8000_0001 -> redirect_pc 0x8000_001C, mepc 0x100, MPIE=1, MIE=0; then mret -> redirect_pc 0x100, MIE=1.
- Write mcycle 0xFFFF_FFFF, mcycleh 0 (COUNTER_W=64) -> next cycles read mcycle 0, mcycleh 1.
- CSRRW to 0xC00 -> csr_illegal=1, no state change; CSRRS 0xC00 wdata 0 -> legal, returns cycle; access 0x7C0 -> illegal, rdata 0.
- trap_valid, mret_valid and CSRRW mepc 0x200 same cycle -> mepc = trap_pc, redirect to mtvec, minstret still increments with retire=1.
